spi_led_ctrl: RTL and testbench
===============================

Name: spi_led_ctrl

Overview:
Command sequencer and LED brightness register file behind spi_slave inside spi_top. It tracks frame boundaries from spi_slave's rx_dv and rx_addr_dv, serves read-response bytes in time for the slave's payload load, and commits LED_SET writes at frame end. It drives per-LED duty values (percent, 0..MAX_DUTY) to the PWM stage, plus status counters.

Parameters:
NUM_LED, 4, number of LED brightness registers; valid addresses 0..NUM_LED-1
CMD_NOP, 8'h00, no-operation command code
CMD_LED_SET, 8'h01, write brightness command code
CMD_LED_READ, 8'h02, read brightness command code
MAX_DUTY, 100, clamp ceiling for written brightness
DUTY_RST, 0, reset value of every brightness register

Ports:
sysclk  in  1  system clock (125 MHz)
rst  in  1  synchronous reset, active high
i_cmd  in  8  spi_slave o_cmd
i_addr  in  8  spi_slave o_addr
i_payload  in  8  spi_slave o_payload
i_rx_dv  in  1  spi_slave rx_dv: high while CS deasserted; rising edge = frame end
i_rx_addr_dv  in  1  spi_slave rx_addr_dv: goes high when address is complete; low again at next frame start
i_rd_bypass  in  1  spi_slave rd_bypass: current frame is LED_READ
o_tx_payload  out  8  read-response byte to spi_slave i_tx_payload (registered)
o_led_duty  out  8*NUM_LED  packed brightness; LED n at [8n+7:8n]
o_wr_pulse  out  1  one-cycle strobe when a register is written
o_err_pulse  out  1  one-cycle strobe on any frame error
o_err_cnt  out  8  saturating error counter
o_frame_cnt  out  16  wrapping count of completed frames (error frames included)
o_state  out  3  current FSM state, debug

Behaviour:
- Reset: state SYNC; o_tx_payload=0; all duty regs=DUTY_RST; o_wr_pulse=o_err_pulse=0; counters=0; rx_dv edge register=1.
- Reset applies on any cycle, including mid-frame. The frame in flight is discarded.
- FSM states: SYNC=0, IDLE=1, RX=2, COMMIT=3.
  - SYNC -> IDLE when i_rx_dv==1. Prevents committing a frame that began before reset released.
  - IDLE -> RX on i_rx_dv falling edge (registered previous value 1, current 0).
  - RX -> COMMIT on i_rx_dv rising edge. Capture i_cmd, i_addr, i_payload, and whether i_rx_addr_dv was seen high during RX (addr_seen flag).
  - COMMIT -> IDLE unconditionally after 1 cycle.
- Read serving:
  - In RX, on every cycle with i_rd_bypass==1 and i_rx_addr_dv==1, register o_tx_payload <= duty[i_addr] if i_addr<NUM_LED, else 8'h00.
  - Latency is exactly 1 cycle; the slave samples one cycle after rx_addr_dv rises.
  - o_tx_payload holds its value otherwise.
- COMMIT decode (captured values), priority order:
  1. addr_seen==0 (frame aborted before address complete): error, no write.
  2. cmd==CMD_NOP: no action.
  3. cmd==CMD_LED_SET, addr<NUM_LED: duty[addr] <= min(payload, MAX_DUTY); o_wr_pulse=1.
  4. cmd==CMD_LED_SET, addr>=NUM_LED: error, no write.
  5. cmd==CMD_LED_READ: no write; error if addr>=NUM_LED.
  6. Any other cmd: error.
- In COMMIT, o_frame_cnt increments (wraps at 16'hFFFF). o_wr_pulse and o_err_pulse are high only in COMMIT, and both are registered.
- Error path: o_err_cnt increments, saturating at 8'hFF.
- Payload compare is unsigned, 8-bit; 8'hFF clamps to MAX_DUTY.
- A write and a read of the same address cannot overlap: writes commit only after the frame ends.
- An i_rx_dv rising edge in SYNC or IDLE is ignored (no commit, no count).

Test Plan:
- Reset released, then SET addr 2 payload 8'd50 -> in COMMIT o_wr_pulse=1; duty[2]=50; o_frame_cnt=1; o_err_cnt=0.
- SET addr 1 payload 8'd200 -> duty[1]=100 (clamped); no error.
- After duty[3]=75, READ addr 3: i_rx_addr_dv rises -> o_tx_payload=8'd75 on the next cycle; no write in COMMIT; o_frame_cnt increments.
- SET addr 8'd7 -> o_err_pulse=1; o_err_cnt=1; all duty values unchanged. READ addr 7 -> o_tx_payload=0, error counted.
- Frame with CS deasserted after 12 bits (i_rx_addr_dv never high) -> error, no write. Cmd 8'h5A -> error. 300 errors -> o_err_cnt=8'hFF.
- rst asserted mid-frame, released while i_rx_dv=0 -> state stays SYNC; the following rx_dv rise causes no commit; the next full SET frame commits normally.

Source files
------------

// File: rtl/spi_led_ctrl_if.sv
// Bundle of signals between spi_slave and the LED command sequencer.
// The slave modport is the sequencer's view; master is the SPI-side view.
interface spi_led_ctrl_if #(
   parameter int NUM_LED = 4
);
   logic [7:0]           i_cmd;
   logic [7:0]           i_addr;
   logic [7:0]           i_payload;
   logic                 i_rx_dv;
   logic                 i_rx_addr_dv;
   logic                 i_rd_bypass;
   logic [7:0]           o_tx_payload;
   logic [8*NUM_LED-1:0] o_led_duty;
   logic                 o_wr_pulse;
   logic                 o_err_pulse;
   logic [7:0]           o_err_cnt;
   logic [15:0]          o_frame_cnt;
   logic [2:0]           o_state;

   modport slave (
      input  i_cmd, i_addr, i_payload, i_rx_dv, i_rx_addr_dv, i_rd_bypass,
      output o_tx_payload, o_led_duty, o_wr_pulse, o_err_pulse,
             o_err_cnt, o_frame_cnt, o_state
   );

   modport master (
      output i_cmd, i_addr, i_payload, i_rx_dv, i_rx_addr_dv, i_rd_bypass,
      input  o_tx_payload, o_led_duty, o_wr_pulse, o_err_pulse,
             o_err_cnt, o_frame_cnt, o_state
   );
endinterface

// File: rtl/spi_led_ctrl.sv
// LED command sequencer: tracks SPI frame boundaries, answers brightness
// reads in time for the slave's payload load, and commits writes at frame end.
module spi_led_ctrl #(
   parameter int         NUM_LED      = 4,
   parameter logic [7:0] CMD_NOP      = 8'h00,
   parameter logic [7:0] CMD_LED_SET  = 8'h01,
   parameter logic [7:0] CMD_LED_READ = 8'h02,
   parameter logic [7:0] MAX_DUTY     = 8'd100,
   parameter logic [7:0] DUTY_RST     = 8'd0
) (
   input  logic          sysclk,
   input  logic          rst,
   spi_led_ctrl_if.slave bus
);
   localparam int         IDX_W     = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
   localparam logic [7:0] NUM_LED_B = 8'(NUM_LED);

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_RX     = 3'd2,
      ST_COMMIT = 3'd3
   } state_t;

   state_t      state_reg, state_next;
   logic        rx_dv_prev_reg;
   logic        addr_seen_reg;
   logic [7:0]  tx_payload_reg;
   logic        wr_pulse_reg, err_pulse_reg;
   logic [7:0]  err_cnt_reg;
   logic [15:0] frame_cnt_reg;
   logic [7:0]  duty_reg [NUM_LED];

   logic             rx_dv_fall, rx_dv_rise;
   logic             addr_in_range;
   logic [IDX_W-1:0] duty_idx;
   logic [7:0]       clamped_payload;
   logic             frame_end, wr_en, err_en;

   assign rx_dv_fall      = rx_dv_prev_reg & ~bus.i_rx_dv;
   assign rx_dv_rise      = ~rx_dv_prev_reg & bus.i_rx_dv;
   assign addr_in_range   = (bus.i_addr < NUM_LED_B);
   assign duty_idx        = bus.i_addr[IDX_W-1:0];
   assign clamped_payload = (bus.i_payload > MAX_DUTY) ? MAX_DUTY : bus.i_payload;

   // State register; SYNC after reset so a frame already in flight is dropped.
   always_ff @(posedge sysclk) begin
      if (rst) state_reg <= ST_SYNC;
      else     state_reg <= state_next;
   end

   // Next state plus frame-end decode; the decode sees the slave's final
   // cmd/addr/payload on the rx_dv rising edge, so its results are registered
   // on the same edge that enters COMMIT.
   always_comb begin
      state_next = state_reg;
      frame_end  = 1'b0;
      wr_en      = 1'b0;
      err_en     = 1'b0;
      case (state_reg)
         ST_SYNC:   if (bus.i_rx_dv) state_next = ST_IDLE;
         ST_IDLE:   if (rx_dv_fall) state_next = ST_RX;
         ST_RX: begin
            if (rx_dv_rise) begin
               state_next = ST_COMMIT;
               frame_end  = 1'b1;
               if (!(addr_seen_reg | bus.i_rx_addr_dv)) begin
                  err_en = 1'b1;
               end else if (bus.i_cmd == CMD_NOP) begin
                  err_en = 1'b0;
               end else if (bus.i_cmd == CMD_LED_SET) begin
                  wr_en  = addr_in_range;
                  err_en = ~addr_in_range;
               end else if (bus.i_cmd == CMD_LED_READ) begin
                  err_en = ~addr_in_range;
               end else begin
                  err_en = 1'b1;
               end
            end
         end
         ST_COMMIT: state_next = ST_IDLE;
         default:   state_next = ST_SYNC;
      endcase
   end

   // Edge detector, address-seen flag, read response, pulses and counters.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         rx_dv_prev_reg <= 1'b1;
         addr_seen_reg  <= 1'b0;
         tx_payload_reg <= 8'h00;
         wr_pulse_reg   <= 1'b0;
         err_pulse_reg  <= 1'b0;
         err_cnt_reg    <= 8'h00;
         frame_cnt_reg  <= 16'h0000;
      end else begin
         rx_dv_prev_reg <= bus.i_rx_dv;
         if (state_reg != ST_RX)    addr_seen_reg <= 1'b0;
         else if (bus.i_rx_addr_dv) addr_seen_reg <= 1'b1;
         if (state_reg == ST_RX && bus.i_rd_bypass && bus.i_rx_addr_dv)
            tx_payload_reg <= addr_in_range ? duty_reg[duty_idx] : 8'h00;
         wr_pulse_reg  <= wr_en;
         err_pulse_reg <= err_en;
         if (frame_end) frame_cnt_reg <= frame_cnt_reg + 16'd1;
         if (err_en && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led
         // Per-LED brightness register, written only by a decoded SET.
         always_ff @(posedge sysclk) begin
            if (rst)
               duty_reg[gi] <= DUTY_RST;
            else if (wr_en && duty_idx == IDX_W'(gi))
               duty_reg[gi] <= clamped_payload;
         end
         assign bus.o_led_duty[8*gi +: 8] = duty_reg[gi];
      end
   endgenerate

   assign bus.o_tx_payload = tx_payload_reg;
   assign bus.o_wr_pulse   = wr_pulse_reg;
   assign bus.o_err_pulse  = err_pulse_reg;
   assign bus.o_err_cnt    = err_cnt_reg;
   assign bus.o_frame_cnt  = frame_cnt_reg;
   assign bus.o_state      = state_reg;
endmodule

// File: tb/tb_spi_led_ctrl.sv
// Self-checking bench for spi_led_ctrl: directed frames, random frames and
// reset cases against a frame-level reference model.
module tb_spi_led_ctrl;
   localparam int NUM_LED = 4;

   logic sysclk = 1'b0;
   logic rst    = 1'b1;
   always #4 sysclk = ~sysclk;

   spi_led_ctrl_if #(.NUM_LED(NUM_LED)) bus();

   spi_led_ctrl #(.NUM_LED(NUM_LED)) dut (
      .sysclk(sysclk),
      .rst   (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int model_duty [NUM_LED];
   int model_err, model_frames, model_tx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_LED; i++) model_duty[i] = 0;
      model_err = 0; model_frames = 0; model_tx = 0;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NUM_LED; i++)
         check($sformatf("%s_duty%0d", tag, i), 32'(bus.o_led_duty[8*i +: 8]), 32'(model_duty[i]));
      check({tag, "_errcnt"}, 32'(bus.o_err_cnt), 32'(model_err));
      check({tag, "_frames"}, 32'(bus.o_frame_cnt), 32'(model_frames));
      check({tag, "_tx"}, 32'(bus.o_tx_payload), 32'(model_tx));
   endtask

   // One complete SPI frame: CS falls, address completes (optionally),
   // payload arrives, CS rises; COMMIT is checked and then the aftermath.
   task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] payload, input bit bypass, input bit give_addr);
      bit in_rng, exp_wr, exp_err;
      in_rng = (addr < NUM_LED);
      bus.i_rx_dv = 1'b0; bus.i_rx_addr_dv = 1'b0; bus.i_rd_bypass = bypass;
      bus.i_cmd = cmd; bus.i_addr = addr; bus.i_payload = 8'h00;
      tick();
      check("rx_state", 32'(bus.o_state), 32'd2);
      tick();
      if (give_addr) begin
         bus.i_rx_addr_dv = 1'b1;
         tick();
         if (bypass) begin
            model_tx = in_rng ? model_duty[addr] : 0;
            check("tx_read", 32'(bus.o_tx_payload), 32'(model_tx));
         end
      end
      bus.i_payload = payload;
      tick(); tick();
      exp_wr = 1'b0; exp_err = 1'b0;
      if (!give_addr)              exp_err = 1'b1;
      else if (cmd == 8'h00)       exp_err = 1'b0;
      else if (cmd == 8'h01) begin exp_wr = in_rng; exp_err = !in_rng; end
      else if (cmd == 8'h02)       exp_err = !in_rng;
      else                         exp_err = 1'b1;
      bus.i_rx_dv = 1'b1;
      tick();
      check("commit_state", 32'(bus.o_state), 32'd3);
      check("commit_wr", 32'(bus.o_wr_pulse), 32'(exp_wr));
      check("commit_err", 32'(bus.o_err_pulse), 32'(exp_err));
      tick();
      if (exp_wr) model_duty[addr] = (payload > 8'd100) ? 100 : int'(payload);
      model_frames = (model_frames + 1) & 32'hFFFF;
      if (exp_err && model_err < 255) model_err++;
      check("post_state", 32'(bus.o_state), 32'd1);
      check("post_wr", 32'(bus.o_wr_pulse), 32'd0);
      check("post_err", 32'(bus.o_err_pulse), 32'd0);
      check_all($sformatf("frame_c%0h_a%0h_p%0h", cmd, addr, payload));
   endtask

   initial begin
      logic [7:0] rcmd;
      bus.i_rx_dv = 1'b1; bus.i_rx_addr_dv = 1'b0; bus.i_rd_bypass = 1'b0;
      bus.i_cmd = 8'h00; bus.i_addr = 8'h00; bus.i_payload = 8'h00;
      model_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      check("rst_state", 32'(bus.o_state), 32'd0);
      check("rst_wr", 32'(bus.o_wr_pulse), 32'd0);
      check("rst_err", 32'(bus.o_err_pulse), 32'd0);
      check_all("rst");
      rst = 1'b0;
      tick();
      check("sync_to_idle", 32'(bus.o_state), 32'd1);

      // Directed frames
      run_frame(8'h01, 8'd2, 8'd50, 1'b0, 1'b1);
      run_frame(8'h01, 8'd1, 8'd200, 1'b0, 1'b1);
      run_frame(8'h01, 8'd3, 8'd75, 1'b0, 1'b1);
      run_frame(8'h02, 8'd3, 8'd0, 1'b1, 1'b1);
      run_frame(8'h01, 8'd7, 8'd9, 1'b0, 1'b1);
      run_frame(8'h02, 8'd7, 8'd0, 1'b1, 1'b1);
      run_frame(8'h01, 8'd0, 8'd33, 1'b0, 1'b0);
      run_frame(8'h5A, 8'd0, 8'd1, 1'b0, 1'b1);
      run_frame(8'h01, 8'd0, 8'hFF, 1'b0, 1'b1);
      run_frame(8'h00, 8'd1, 8'd5, 1'b0, 1'b1);
      run_frame(8'h01, 8'd0, 8'd100, 1'b0, 1'b1);
      run_frame(8'h01, 8'd3, 8'd101, 1'b0, 1'b1);
      run_frame(8'h02, 8'd0, 8'd0, 1'b1, 1'b1);

      // Random frames
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       rcmd = 8'h00;
            1:       rcmd = 8'h01;
            2:       rcmd = 8'h02;
            default: rcmd = 8'($urandom);
         endcase
         run_frame(rcmd, 8'($urandom_range(0, 7)), 8'($urandom),
                   (rcmd == 8'h02), ($urandom_range(0, 7) != 0));
      end

      // Error counter saturation
      for (int n = 0; n < 300; n++) run_frame(8'h5A, 8'd0, 8'd0, 1'b0, 1'b1);
      check("err_saturated", 32'(bus.o_err_cnt), 32'hFF);

      // Reset in the middle of a frame, released while CS is still asserted
      bus.i_rx_dv = 1'b0; bus.i_rx_addr_dv = 1'b0; bus.i_rd_bypass = 1'b0;
      bus.i_cmd = 8'h01; bus.i_addr = 8'd0; bus.i_payload = 8'd77;
      tick(); tick();
      bus.i_rx_addr_dv = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      tick();
      check("midrst_sync0", 32'(bus.o_state), 32'd0);
      tick();
      check("midrst_sync1", 32'(bus.o_state), 32'd0);
      check_all("midrst");
      bus.i_rx_dv = 1'b1;
      tick();
      check("midrst_idle", 32'(bus.o_state), 32'd1);
      check("midrst_nowr", 32'(bus.o_wr_pulse), 32'd0);
      tick();
      check("midrst_idle2", 32'(bus.o_state), 32'd1);
      check_all("midrst_rise");
      run_frame(8'h01, 8'd0, 8'd42, 1'b0, 1'b1);
      run_frame(8'h02, 8'd0, 8'd0, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
